ddr3_wr_control: RTL
====================

# ddr3_wr_control

Write-side companion to the DDR3 read control block. It drains 128-bit bursts from the DDR3 write FIFO and delivers them to the memory controller user interface as write commands and write data. Each transfer is a contiguous run of `ddr3_wr_burst_cnt` bursts starting at burst address `ddr3_wr_start_addr`. It sits in the DDR3 user-clock domain between the fill-packing logic and the memory controller, and reports completion back to the requesting logic.

## Interface
- No parameters; widths are fixed.
- `clk` in 1: DDR3 user-interface clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ddr3_wr_start_addr` in 23: first 128-bit burst address; sampled on the start pulse.
- `ddr3_wr_burst_cnt` in 24: number of bursts to write; sampled on the start pulse.
- `enable_writing` in 1: level request from another clock domain; high means start, low means return to idle.
- `writing_done` out 1: high in DONE.
- `ddr3_wr_fifo_dout` in 128: write-FIFO head word (first-word-fall-through).
- `ddr3_wr_fifo_empty` in 1: write FIFO has no word.
- `ddr3_wr_fifo_rd_en` out 1: pop the FIFO head.
- `app_rdy` in 1: controller accepts a command.
- `app_en` out 1: command valid.
- `app_cmd` out 3: constant 3'b000 (write).
- `ddr3_wr_addr` out 26: `{addr_gen[22:0], 3'b000}`.
- `app_wdf_rdy` in 1: controller accepts write data.
- `app_wdf_wren` out 1: write data valid.
- `app_wdf_end` out 1: equal to `app_wdf_wren` (one beat per burst).
- `app_wdf_data` out 128: equal to `ddr3_wr_fifo_dout`.
- `app_wdf_mask` out 16: constant 0.

## Operation
- **Synchronizer:** three-flop chain `sync1..sync3` on `enable_writing`. `start_pulse <= sync2 & !sync3`.
- **Accept terms:**
  - `cmd_accept = app_en & app_rdy`
  - `data_accept = app_wdf_wren & app_wdf_rdy`
- **`addr_gen` (23 b):** loads the start address on `start_pulse`, else increments on `cmd_accept`. It wraps modulo 2^23 with no error.
- **`addr_cntr` (24 b):** loads the burst count on `start_pulse`, else decrements on `cmd_accept`. It never decrements below 0.
- **`data_cntr` (24 b):** loads the burst count on `start_pulse`, else decrements on `data_accept`. It never decrements below 0.
- **`data_ahead` (2 b, range 0..2):** counts data beats accepted but not yet matched by a command.
  - +1 on `data_accept` only; −1 on `cmd_accept` only; unchanged when both or neither occur.
  - Cleared on `start_pulse`.
- **States:** IDLE, WRITE, DONE.
  - IDLE → WRITE when `sync3` = 1.
  - WRITE → DONE when `addr_cntr` == 0, `data_cntr` == 0 and `data_ahead` == 0.
  - DONE holds.
  - Any state → IDLE on the clock when `sync2` = 0; this is a synchronous abort that drops outstanding work.
- **Data leads command:**
  - `app_wdf_wren = WRITE & !ddr3_wr_fifo_empty & (data_cntr != 0) & (data_ahead != 2)`
  - `app_en = WRITE & (addr_cntr != 0) & (data_ahead != 0)`
  - A command is never presented before its data beat has been accepted.
- `ddr3_wr_fifo_rd_en = data_accept`.
- Burst count 0: the WRITE → DONE condition is true on the first WRITE cycle, so the next state is DONE and nothing is issued.

## Timing
- **Reset values:** all counters and `addr_gen` = 0, state = IDLE, sync flops = 0. Consequently `app_en`, `app_wdf_wren`, `app_wdf_end`, `ddr3_wr_fifo_rd_en` and `writing_done` = 0, and `ddr3_wr_addr` = 0.
- **Start latency:**
  - `enable_writing` rises before edge E0.
  - `sync3`, `start_pulse` and state = WRITE all take effect at edge E2, and the counters load at E2.
  - The earliest `app_wdf_wren` is the cycle after E2. The earliest `app_en` is one cycle after the first `data_accept`.
- Both handshakes are combinational-valid and level-held. A deasserted `app_rdy` or `app_wdf_rdy` holds the address and data stable; the FIFO is not popped.
- **Simultaneous `data_accept` and `cmd_accept`:** `data_ahead` is unchanged, and both counters decrement in the same cycle.
- **FIFO empty mid-transfer:** `app_wdf_wren` drops. Commands still drain while `data_ahead` > 0.
- `writing_done` asserts the cycle after the last of the counters/`data_ahead` reaches zero, and deasserts two edges after `enable_writing` falls.
- **Async reset mid-transfer:** all outputs go to reset values immediately; there is no partial completion.

## Test plan
- **Basic transfer:** start address 0x000010, count 4, FIFO preloaded with 4 words, ready signals always high.
  - Expect 4 data beats, then 4 commands with `ddr3_wr_addr` = 0x80, 0x88, 0x90, 0x98.
  - Expect 4 FIFO pops, then `writing_done` = 1.
- **Backpressure:**
  - `app_rdy` low for 5 cycles: `data_ahead` saturates at 2 and `app_wdf_wren` drops.
  - `app_rdy` released: all 8 commands of an 8-burst transfer complete in order.
- **FIFO starvation:** count 3 with the FIFO holding 1 word, then 2 more words after 10 cycles.
  - No `app_en` while `data_ahead` = 0.
  - Completes with 3 commands and 3 beats.
- **Edge cases:**
  - Count 0: DONE within 2 cycles of WRITE entry, with no `app_en` or `app_wdf_wren`.
  - Start address 0x7FFFFF, count 2: addresses 0x3FFFFF8 then 0x0000000.
- **Abort and reset:**
  - Drop `enable_writing` mid-transfer: state is IDLE two edges later with all handshakes low.
  - Pulse `reset_n` low mid-transfer: outputs are zero with no clock edge required.
  - Restart with count 1: completes normally.

Source files
------------

// File: rtl/ddr3_wr_control.sv
// Drains 128-bit bursts from the DDR3 write FIFO into the memory controller user
// interface: write data is always accepted ahead of the matching write command.
//
// state | meaning
// IDLE  | waiting for a synchronized start request
// WRITE | issuing data beats and commands until both counters and data_ahead are zero
// DONE  | transfer complete, writing_done high until enable_writing drops
module ddr3_wr_control (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [22:0]   ddr3_wr_start_addr,
   input  logic [23:0]   ddr3_wr_burst_cnt,
   input  logic          enable_writing,
   output logic          writing_done,
   input  logic [127:0]  ddr3_wr_fifo_dout,
   input  logic          ddr3_wr_fifo_empty,
   output logic          ddr3_wr_fifo_rd_en,
   input  logic          app_rdy,
   output logic          app_en,
   output logic [2:0]    app_cmd,
   output logic [25:0]   ddr3_wr_addr,
   input  logic          app_wdf_rdy,
   output logic          app_wdf_wren,
   output logic          app_wdf_end,
   output logic [127:0]  app_wdf_data,
   output logic [15:0]   app_wdf_mask
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          sync1, sync2, sync3;
   logic          start_pulse;
   logic          in_write;
   logic          cmd_accept, data_accept;
   logic [22:0]   addr_gen;
   logic [23:0]   addr_cntr, data_cntr;
   logic [1:0]    data_ahead;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= enable_writing;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Decoded one flop early so the counters load and WRITE is entered on the
   // same edge that sets sync3; likewise the abort uses sync1 so the state
   // returns to IDLE on the edge that clears sync2.
   assign start_pulse = sync2 & ~sync3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_pulse) state_nxt = WRITE;
         WRITE:   if (addr_cntr == 24'd0 && data_cntr == 24'd0 && data_ahead == 2'd0)
                     state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (!sync1) state_nxt = IDLE;
   end

   always_comb begin
      in_write     = 1'b0;
      writing_done = 1'b0;
      case (state)
         WRITE:   in_write     = 1'b1;
         DONE:    writing_done = 1'b1;
         default: ;
      endcase
   end

   // Data may run at most two beats ahead; a command needs a beat already banked.
   assign app_wdf_wren = in_write & ~ddr3_wr_fifo_empty & (data_cntr != 24'd0) & (data_ahead != 2'd2);
   assign app_en       = in_write & (addr_cntr != 24'd0) & (data_ahead != 2'd0);
   assign cmd_accept   = app_en & app_rdy;
   assign data_accept  = app_wdf_wren & app_wdf_rdy;

   assign ddr3_wr_fifo_rd_en = data_accept;
   assign app_cmd            = 3'b000;
   assign ddr3_wr_addr       = {addr_gen, 3'b000};
   assign app_wdf_end        = app_wdf_wren;
   assign app_wdf_data       = ddr3_wr_fifo_dout;
   assign app_wdf_mask       = 16'h0000;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_gen   <= '0;
         addr_cntr  <= '0;
         data_cntr  <= '0;
         data_ahead <= '0;
      end else if (start_pulse) begin
         addr_gen   <= ddr3_wr_start_addr;
         addr_cntr  <= ddr3_wr_burst_cnt;
         data_cntr  <= ddr3_wr_burst_cnt;
         data_ahead <= '0;
      end else begin
         if (cmd_accept) begin
            addr_gen <= addr_gen + 23'd1;
            if (addr_cntr != 24'd0) addr_cntr <= addr_cntr - 24'd1;
         end
         if (data_accept && data_cntr != 24'd0) data_cntr <= data_cntr - 24'd1;
         case ({data_accept, cmd_accept})
            2'b10:   data_ahead <= data_ahead + 2'd1;
            2'b01:   data_ahead <= data_ahead - 2'd1;
            default: ;
         endcase
      end
   end

endmodule
